// File: rtl/inst_cache_pkg.sv
// Shared types and constants for the instruction cache slice.
// No logic, so no latency.
// No flow control of its own.
package inst_cache_pkg;

  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;
  localparam int MMU_DATA_LAT_DEF = 3;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/icache_tag_array.sv
// Direct-mapped line store: valid bits, tags and one data word per line.
// Read port is combinational; the write lands on the next clock edge.
// No backpressure; flush_all clears every valid bit and wins over a same-edge write.
module icache_tag_array
  import inst_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 30 - INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output logic                   rd_vld,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [DATA_W-1:0]      rd_dat,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [DATA_W-1:0]      wr_dat,
  input  logic                   flush_all
);

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [LINES-1:0]     vld_q;
  logic [TAG_WIDTH-1:0] tag_q [LINES];
  data_t                dat_q [LINES];

  assign rd_vld = vld_q[rd_idx];
  assign rd_tag = tag_q[rd_idx];
  assign rd_dat = dat_q[rd_idx];

  // Valid bits: flush clears every line and overrides a fill on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else if (flush_all) begin
      vld_q <= '0;
    end else if (wr_en) begin
      vld_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_en && !flush_all) begin
      tag_q[wr_idx] <= wr_tag;
      dat_q[wr_idx] <= wr_dat;
    end
  end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache in front of the MMU; ICACHE_PERF_EN adds hit/miss counters.
// Hit answers 1 cycle after the request; a miss answers REQ cycles + MMU_DATA_LAT + 1 after it.
// One response pulse per request, no new request taken in the pulse cycle; rdy low freezes all state.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = 6,
  parameter int MMU_DATA_LAT = MMU_DATA_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] addr_from_fetcher,
  input  logic              valid_from_fetcher,
  output logic [DATA_W-1:0] inst_to_fetcher,
  output logic              ready_to_fetcher,
  input  logic              flush,
  output logic [ADDR_W-1:0] addr_to_mmu,
  output logic              valid_to_mmu,
  input  logic              ready_from_mmu,
  input  logic [DATA_W-1:0] data_from_mmu
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int TAG_WIDTH = 30 - INDEX_WIDTH;
  localparam int CNT_W     = $clog2(MMU_DATA_LAT + 1);

  state_t             state_q, state_d;
  addr_t              addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               vmmu_q, vmmu_d;
  logic               rsp_q, rsp_d;
  data_t              inst_q, inst_d;
  logic               drop_q, drop_d;
  logic               wr_en, take_hit, take_miss;

  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   rd_vld;
  logic [TAG_WIDTH-1:0]   rd_tag;
  data_t                  rd_dat;
  logic                   hit;
  logic                   unused_lsb;

  // The two byte-offset bits never select anything in a word cache.
  assign unused_lsb = ^addr_from_fetcher[1:0];

  assign req_idx = addr_from_fetcher[INDEX_WIDTH+1:2];
  assign req_tag = addr_from_fetcher[ADDR_W-1:INDEX_WIDTH+2];
  assign hit     = rd_vld && (rd_tag == req_tag);

  assign inst_to_fetcher  = inst_q;
  assign ready_to_fetcher = rsp_q;
  assign addr_to_mmu      = addr_q;
  assign valid_to_mmu     = vmmu_q;

  icache_tag_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_tags (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (req_idx),
    .rd_vld    (rd_vld),
    .rd_tag    (rd_tag),
    .rd_dat    (rd_dat),
    .wr_en     (wr_en && rdy),
    .wr_idx    (addr_q[INDEX_WIDTH+1:2]),
    .wr_tag    (addr_q[ADDR_W-1:INDEX_WIDTH+2]),
    .wr_dat    (data_from_mmu),
    .flush_all (flush && rdy)
  );

  // Next-state and output decode; a flush mid-miss lets the MMU finish but drops its word.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    vmmu_d    = vmmu_q;
    rsp_d     = 1'b0;
    inst_d    = inst_q;
    drop_d    = drop_q;
    wr_en     = 1'b0;
    take_hit  = 1'b0;
    take_miss = 1'b0;
    case (state_q)
      IDLE: begin
        // rsp_q gives the fetcher one cycle to drop or change its request.
        if (!flush && valid_from_fetcher && !rsp_q) begin
          addr_d = {addr_from_fetcher[ADDR_W-1:2], 2'b00};
          if (hit) begin
            rsp_d    = 1'b1;
            inst_d   = rd_dat;
            take_hit = 1'b1;
          end else begin
            state_d   = REQ;
            vmmu_d    = 1'b1;
            drop_d    = 1'b0;
            take_miss = 1'b1;
          end
        end
      end
      REQ: begin
        if (flush) drop_d = 1'b1;
        if (ready_from_mmu) begin
          vmmu_d  = 1'b0;
          cnt_d   = CNT_W'(MMU_DATA_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) drop_d = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (!(drop_q || flush)) begin
            wr_en  = 1'b1;
            rsp_d  = 1'b1;
            inst_d = data_from_mmu;
          end
        end
      end
      default: begin
        state_d = IDLE;
        vmmu_d  = 1'b0;
      end
    endcase
  end

  // Control registers; rdy low holds every one of them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      vmmu_q  <= 1'b0;
      rsp_q   <= 1'b0;
      inst_q  <= '0;
      drop_q  <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      vmmu_q  <= vmmu_d;
      rsp_q   <= rsp_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
    end
  end

`ifdef ICACHE_PERF_EN
  // Free-running hit/miss counters; they wrap and survive flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (rdy) begin
      if (take_hit)  hit_count  <= hit_count + 32'd1;
      if (take_miss) miss_count <= miss_count + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = take_hit ^ take_miss;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache with a small MMU model and a response scoreboard.
// Inputs are driven and outputs sampled on the falling clock edge.
// Every expected instruction is queued when its request is issued.
module tb_inst_cache;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst, rdy, valid_from_fetcher, flush, ready_from_mmu;
  logic [31:0] addr_from_fetcher, data_from_mmu;
  logic [31:0] inst_to_fetcher, addr_to_mmu;
  logic        ready_to_fetcher, valid_to_mmu;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  inst_cache #(.INDEX_WIDTH(6), .MMU_DATA_LAT(LAT)) dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .addr_from_fetcher  (addr_from_fetcher),
    .valid_from_fetcher (valid_from_fetcher),
    .inst_to_fetcher    (inst_to_fetcher),
    .ready_to_fetcher   (ready_to_fetcher),
    .flush              (flush),
    .addr_to_mmu        (addr_to_mmu),
    .valid_to_mmu       (valid_to_mmu),
    .ready_from_mmu     (ready_from_mmu),
    .data_from_mmu      (data_from_mmu)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count          (hit_count),
    .miss_count         (miss_count)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          n_resp = 0, last_resp_cyc = 0;
  int          n_acc = 0, acc_cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mmu_word;
  logic        mmu_en, mmu_busy, saw_mmu;
  int          mmu_delay, mmu_cd, req_seen;
  logic [31:0] first_mmu_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs, score responses, then run the MMU model.
  task automatic tick();
    logic acc, en;
    acc = ready_from_mmu && valid_to_mmu && rdy && rst;
    en  = rdy && rst;
    @(negedge clk);
    cyc++;
    if (en && ready_to_fetcher) begin
      n_resp++;
      last_resp_cyc = cyc;
      chk("resp_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("resp_data", inst_to_fetcher, exp_q.pop_front());
    end
    if (valid_to_mmu && !saw_mmu) begin
      saw_mmu = 1'b1;
      first_mmu_addr = addr_to_mmu;
    end
    // MMU: word is garbage until LAT cycles after the accepting edge.
    if (acc) begin
      ready_from_mmu = 1'b0;
      mmu_busy = 1'b1;
      mmu_cd = LAT - 1;
      acc_cyc = cyc;
      n_acc++;
      data_from_mmu = 32'hDEAD_BEEF;
    end else if (mmu_busy && mmu_cd > 0) begin
      mmu_cd--;
    end
    if (mmu_busy && mmu_cd == 0) begin
      data_from_mmu = mmu_word;
      mmu_busy = 1'b0;
    end
    if (!mmu_busy && !acc && !ready_from_mmu && valid_to_mmu && mmu_en && rst) begin
      if (req_seen >= mmu_delay) ready_from_mmu = 1'b1;
      else req_seen++;
    end
    if (!valid_to_mmu) req_seen = 0;
  endtask

  task automatic wait_resp(input int budget, input string tag);
    int n0, k;
    n0 = n_resp;
    k = 0;
    while (n_resp == n0 && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_resp_cnt"}, 32'(n_resp - n0), 32'd1);
  endtask

  task automatic wait_acc(input int budget, input string tag);
    int n0, k;
    n0 = n_acc;
    k = 0;
    while (n_acc == n0 && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_acc_cnt"}, 32'(n_acc - n0), 32'd1);
  endtask

  // Miss latency is measured from the cycle after the MMU accepted: LAT more cycles.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input logic miss,
                       input string tag);
    int c0;
    saw_mmu = 1'b0;
    exp_q.push_back(exp);
    addr_from_fetcher = a;
    valid_from_fetcher = 1'b1;
    c0 = cyc;
    wait_resp(40, tag);
    valid_from_fetcher = 1'b0;
    chk({tag, "_miss"}, 32'(saw_mmu), 32'(miss));
    if (miss) chk({tag, "_lat"}, 32'(last_resp_cyc - acc_cyc), 32'(LAT));
    else chk({tag, "_lat"}, 32'(last_resp_cyc - c0), 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    valid_from_fetcher = 1'b0; addr_from_fetcher = '0;
    ready_from_mmu = 1'b0; data_from_mmu = '0;
    mmu_word = '0; mmu_en = 1'b1; mmu_delay = 1; mmu_cd = 0; req_seen = 0;
    mmu_busy = 1'b0; saw_mmu = 1'b0; first_mmu_addr = '0;
    repeat (2) tick();
    chk("rst_ready", {31'b0, ready_to_fetcher}, 32'd0);
    chk("rst_vmmu", {31'b0, valid_to_mmu}, 32'd0);
    chk("rst_inst", inst_to_fetcher, 32'd0);
    chk("rst_addr", addr_to_mmu, 32'd0);
`ifdef ICACHE_PERF_EN
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
`endif
    rst = 1'b1;
    tick();

    // Cold miss, hit, eviction by a same-index different-tag address.
    mmu_word = 32'h0000_0013;
    fetch(32'h0000_1000, 32'h0000_0013, 1'b1, "cold");
    chk("cold_mmu_addr", first_mmu_addr, 32'h0000_1000);
    fetch(32'h0000_1000, 32'h0000_0013, 1'b0, "hit");
    mmu_word = 32'h0000_0093;
    fetch(32'h0000_1100, 32'h0000_0093, 1'b1, "evict");
    mmu_word = 32'h0000_0013;
    fetch(32'h0000_1000, 32'h0000_0013, 1'b1, "refetch");

    // Byte offset ignored on lookup and on the MMU address.
    mmu_word = 32'h0000_0513;
    fetch(32'h0000_1006, 32'h0000_0513, 1'b1, "unalign_miss");
    chk("unalign_mmu_addr", first_mmu_addr, 32'h0000_1004);
    fetch(32'h0000_1002, 32'h0000_0013, 1'b0, "unalign_hit");

    // Flush in IDLE ignores the same-cycle request and invalidates the line.
    addr_from_fetcher = 32'h0000_1000;
    valid_from_fetcher = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle_vmmu", {31'b0, valid_to_mmu}, 32'd0);
    mmu_word = 32'h0000_0013;
    fetch(32'h0000_1000, 32'h0000_0013, 1'b1, "post_flush");

    // Flush during WAIT: no response and nothing installed.
    mmu_word = 32'hAAAA_0001;
    addr_from_fetcher = 32'h0000_2000;
    valid_from_fetcher = 1'b1;
    r0 = n_resp;
    wait_acc(20, "flw");
    flush = 1'b1;
    valid_from_fetcher = 1'b0;
    tick();
    flush = 1'b0;
    repeat (8) tick();
    chk("flush_wait_no_rsp", 32'(n_resp - r0), 32'd0);
    chk("flush_wait_vmmu", {31'b0, valid_to_mmu}, 32'd0);
    fetch(32'h0000_2000, 32'hAAAA_0001, 1'b1, "after_flush_wait");
    mmu_word = 32'h0000_0013;
    fetch(32'h0000_1000, 32'h0000_0013, 1'b1, "flushed_line");

    // rdy low freezes REQ for 5 cycles, then WAIT for 3 cycles.
    mmu_en = 1'b0;
    mmu_word = 32'h0000_0073;
    exp_q.push_back(32'h0000_0073);
    addr_from_fetcher = 32'h0000_3000;
    valid_from_fetcher = 1'b1;
    saw_mmu = 1'b0;
    for (int k = 0; k < 10 && !valid_to_mmu; k++) tick();
    chk("frz_req_seen", {31'b0, valid_to_mmu}, 32'd1);
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("frz_vmmu", {31'b0, valid_to_mmu}, 32'd1);
    end
    chk("frz_addr", addr_to_mmu, 32'h0000_3000);
    rdy = 1'b1;
    mmu_en = 1'b1;
    wait_acc(20, "frz");
    rdy = 1'b0;
    repeat (3) tick();
    rdy = 1'b1;
    wait_resp(20, "frz");
    valid_from_fetcher = 1'b0;
    chk("frz_wait_lat", 32'(last_resp_cyc - acc_cyc), 32'(LAT + 3));
    tick();

    // Asynchronous reset in the middle of WAIT.
    mmu_word = 32'h0000_0017;
    addr_from_fetcher = 32'h0000_4000;
    valid_from_fetcher = 1'b1;
    wait_acc(20, "arst");
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ready", {31'b0, ready_to_fetcher}, 32'd0);
    chk("arst_vmmu", {31'b0, valid_to_mmu}, 32'd0);
    chk("arst_inst", inst_to_fetcher, 32'd0);
    chk("arst_addr", addr_to_mmu, 32'd0);
    valid_from_fetcher = 1'b0;
    ready_from_mmu = 1'b0;
    mmu_busy = 1'b0;
    req_seen = 0;
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    mmu_word = 32'h0000_0013;
    fetch(32'h0000_1000, 32'h0000_0013, 1'b1, "post_rst_miss");
    fetch(32'h0000_1000, 32'h0000_0013, 1'b0, "post_rst_hit");
`ifdef ICACHE_PERF_EN
    chk("perf_hits", hit_count, 32'd1);
    chk("perf_misses", miss_count, 32'd1);
`endif
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
